// File: rtl/input_shift_register_if.sv
// RX-side FIFO handshake of the input shift register.
// The ISR is the master: it drives the push strobe and data word,
// and observes the FIFO full flag.
interface input_shift_register_if;
  logic        fifo_push_en;
  logic [31:0] fifo_data;
  logic        fifo_full;

  modport master (
    output fifo_push_en,
    output fifo_data,
    input  fifo_full
  );

  modport slave (
    input  fifo_push_en,
    input  fifo_data,
    output fifo_full
  );
endinterface

// File: rtl/input_shift_register.sv
// Input shift register for one PIO state machine. Accumulates IN bits
// into a 32-bit register and hands completed words to the RX FIFO,
// either on an explicit PUSH or automatically once the bit count
// reaches the autopush threshold. Push strobe, push data and stall are
// combinational so the FIFO captures the word on the same edge that
// clears the register.
module input_shift_register (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     data_in,
  input  logic                            shift_en,
  input  logic [5:0]                      shift_count,
  input  logic                            shiftdir,
  input  logic                            push_req,
  input  logic                            push_block,
  input  logic                            autopush,
  input  logic [4:0]                      push_thresh,
  input_shift_register_if.master          fifo_if,
  output logic [31:0]                     isr,
  output logic [5:0]                      shift_counter,
  output logic                            stall
);

  logic [31:0] isr_r;
  logic [5:0]  shift_counter_r;

  logic [5:0]  n_s;
  logic [5:0]  thresh_s;
  logic [6:0]  sum_s;
  logic [5:0]  cnt_s;
  logic [31:0] isr_shift_s;
  logic [31:0] isr_nxt_s;
  logic [5:0]  cnt_nxt_s;
  logic        push_en_s;
  logic [31:0] push_data_s;
  logic        stall_s;

  // Effective shift count, threshold and saturating bit count.
  always_comb begin
    n_s      = 6'd32;
    thresh_s = 6'd32;
    if ((shift_count == 6'd0) || (shift_count > 6'd32)) begin
      n_s = 6'd32;
    end else begin
      n_s = shift_count;
    end
    if (push_thresh == 5'd0) begin
      thresh_s = 6'd32;
    end else begin
      thresh_s = {1'b0, push_thresh};
    end
    sum_s = {1'b0, shift_counter_r} + {1'b0, n_s};
    if (sum_s > 7'd32) begin
      cnt_s = 6'd32;
    end else begin
      cnt_s = sum_s[5:0];
    end
  end

  // Shifted register value: new bits enter at the MSB end when shifting
  // right and at the LSB end when shifting left; a full-width shift
  // simply replaces the register with the source.
  always_comb begin
    isr_shift_s = data_in;
    if (n_s == 6'd32) begin
      isr_shift_s = data_in;
    end else if (shiftdir) begin
      isr_shift_s = (isr_r >> n_s) | (data_in << (6'd32 - n_s));
    end else begin
      isr_shift_s = (isr_r << n_s) | (data_in & ((32'd1 << n_s) - 32'd1));
    end
  end

  // Command decode: IN has priority over PUSH; a blocked command holds
  // all state so the FSM can retry it without double-applying the shift.
  always_comb begin
    isr_nxt_s   = isr_r;
    cnt_nxt_s   = shift_counter_r;
    push_en_s   = 1'b0;
    push_data_s = isr_r;
    stall_s     = 1'b0;
    if (rst) begin
      isr_nxt_s = 32'd0;
      cnt_nxt_s = 6'd0;
    end else if (shift_en) begin
      push_data_s = isr_shift_s;
      if (autopush && (cnt_s >= thresh_s)) begin
        if (fifo_if.fifo_full) begin
          stall_s = 1'b1;
        end else begin
          push_en_s = 1'b1;
          isr_nxt_s = 32'd0;
          cnt_nxt_s = 6'd0;
        end
      end else begin
        isr_nxt_s = isr_shift_s;
        cnt_nxt_s = cnt_s;
      end
    end else if (push_req) begin
      if (!fifo_if.fifo_full) begin
        push_en_s = 1'b1;
        isr_nxt_s = 32'd0;
        cnt_nxt_s = 6'd0;
      end else if (push_block) begin
        stall_s = 1'b1;
      end else begin
        isr_nxt_s = 32'd0;
        cnt_nxt_s = 6'd0;
      end
    end else begin
      isr_nxt_s = isr_r;
      cnt_nxt_s = shift_counter_r;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      isr_r           <= 32'd0;
      shift_counter_r <= 6'd0;
    end else begin
      isr_r           <= isr_nxt_s;
      shift_counter_r <= cnt_nxt_s;
    end
  end

  // Output drive.
  always_comb begin
    fifo_if.fifo_push_en = push_en_s;
    fifo_if.fifo_data    = push_data_s;
    stall                = stall_s;
    isr                  = isr_r;
    shift_counter        = shift_counter_r;
  end

endmodule

// File: tb/tb_input_shift_register.sv
// Directed self-checking bench for input_shift_register.
// Inputs change on the falling edge; combinational outputs are checked
// 1 ns later, register outputs on the following falling edge.
module tb_input_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        shift_en;
  logic [5:0]  shift_count;
  logic        shiftdir;
  logic        push_req;
  logic        push_block;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic [31:0] isr;
  logic [5:0]  shift_counter;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  input_shift_register_if u_if ();

  input_shift_register dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .shift_en      (shift_en),
    .shift_count   (shift_count),
    .shiftdir      (shiftdir),
    .push_req      (push_req),
    .push_block    (push_block),
    .autopush      (autopush),
    .push_thresh   (push_thresh),
    .fifo_if       (u_if.master),
    .isr           (isr),
    .shift_counter (shift_counter),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic idle();
    shift_en = 1'b0; push_req = 1'b0; push_block = 1'b0;
    u_if.fifo_full = 1'b0; data_in = 32'd0;
  endtask

  task automatic do_in(input logic [5:0] n, input logic dir, input logic [31:0] d, input logic full);
    shift_en = 1'b1; push_req = 1'b0; shift_count = n; shiftdir = dir;
    data_in = d; u_if.fifo_full = full;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; shift_en = 1'b1; push_req = 1'b1; autopush = 1'b1;
    push_thresh = 5'd1; shift_count = 6'd32; data_in = 32'hFFFF_FFFF;
    u_if.fifo_full = 1'b1; push_block = 1'b1;
    #1;
    n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL reset_push act=%b exp=0", u_if.fifo_push_en); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall act=%b exp=0", stall); end
    u_if.fifo_full = 1'b0;
    #1;
    n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL reset_push2 act=%b exp=0", u_if.fifo_push_en); end
    @(negedge clk);
    idle(); rst = 1'b0; autopush = 1'b0;
    n_checks++; if (isr !== 32'd0) begin n_fail++; $display("FAIL reset_isr act=%h exp=0", isr); end
    n_checks++; if (shift_counter !== 6'd0) begin n_fail++; $display("FAIL reset_cnt act=%0d exp=0", shift_counter); end
  endtask

  task automatic test_shift_left();
    do_reset(); autopush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_in(6'd8, 1'b0, 32'h0000_00A5, 1'b0);
      #1;
      n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL left_push act=%b exp=0", u_if.fifo_push_en); end
      @(negedge clk);
    end
    idle();
    n_checks++; if (isr !== 32'h0000_A5A5) begin n_fail++; $display("FAIL left_isr act=%h exp=0000a5a5", isr); end
    n_checks++; if (shift_counter !== 6'd16) begin n_fail++; $display("FAIL left_cnt act=%0d exp=16", shift_counter); end
  endtask

  task automatic test_shift_right();
    do_reset(); autopush = 1'b0;
    do_in(6'd4, 1'b1, 32'h0000_000F, 1'b0);
    @(negedge clk);
    n_checks++; if (isr !== 32'hF000_0000) begin n_fail++; $display("FAIL right1_isr act=%h exp=f0000000", isr); end
    n_checks++; if (shift_counter !== 6'd4) begin n_fail++; $display("FAIL right1_cnt act=%0d exp=4", shift_counter); end
    for (int i = 0; i < 7; i++) @(negedge clk);
    n_checks++; if (isr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL right8_isr act=%h exp=ffffffff", isr); end
    n_checks++; if (shift_counter !== 6'd32) begin n_fail++; $display("FAIL right8_cnt act=%0d exp=32", shift_counter); end
    @(negedge clk);
    n_checks++; if (shift_counter !== 6'd32) begin n_fail++; $display("FAIL right9_cnt act=%0d exp=32", shift_counter); end
    do_reset();
    do_in(6'd8, 1'b1, 32'hFFFF_FFAB, 1'b0);
    @(negedge clk);
    do_in(6'd4, 1'b1, 32'h0000_0075, 1'b0);
    @(negedge clk);
    idle();
    n_checks++; if (isr !== 32'h5AB0_0000) begin n_fail++; $display("FAIL right_mix_isr act=%h exp=5ab00000", isr); end
    n_checks++; if (shift_counter !== 6'd12) begin n_fail++; $display("FAIL right_mix_cnt act=%0d exp=12", shift_counter); end
  endtask

  task automatic test_autopush();
    logic [31:0] bytes_v [4];
    bytes_v[0] = 32'h11; bytes_v[1] = 32'h22; bytes_v[2] = 32'h33; bytes_v[3] = 32'h44;
    do_reset(); autopush = 1'b1; push_thresh = 5'd0;
    for (int i = 0; i < 4; i++) begin
      do_in(6'd8, 1'b0, bytes_v[i], 1'b0);
      #1;
      if (i < 3) begin
        n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL ap_early_push i=%0d act=%b exp=0", i, u_if.fifo_push_en); end
      end else begin
        n_checks++; if (u_if.fifo_push_en !== 1'b1) begin n_fail++; $display("FAIL ap_push act=%b exp=1", u_if.fifo_push_en); end
        n_checks++; if (u_if.fifo_data !== 32'h1122_3344) begin n_fail++; $display("FAIL ap_data act=%h exp=11223344", u_if.fifo_data); end
      end
      @(negedge clk);
    end
    idle();
    n_checks++; if (isr !== 32'd0) begin n_fail++; $display("FAIL ap_isr act=%h exp=0", isr); end
    n_checks++; if (shift_counter !== 6'd0) begin n_fail++; $display("FAIL ap_cnt act=%0d exp=0", shift_counter); end
  endtask

  task automatic test_autopush_stall();
    do_reset(); autopush = 1'b1; push_thresh = 5'd0;
    do_in(6'd8, 1'b0, 32'h11, 1'b0); @(negedge clk);
    do_in(6'd8, 1'b0, 32'h22, 1'b0); @(negedge clk);
    do_in(6'd8, 1'b0, 32'h33, 1'b0); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_in(6'd8, 1'b0, 32'h44, 1'b1);
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL aps_stall i=%0d act=%b exp=1", i, stall); end
      n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL aps_push i=%0d act=%b exp=0", i, u_if.fifo_push_en); end
      @(negedge clk);
      n_checks++; if (isr !== 32'h0011_2233) begin n_fail++; $display("FAIL aps_isr i=%0d act=%h exp=00112233", i, isr); end
      n_checks++; if (shift_counter !== 6'd24) begin n_fail++; $display("FAIL aps_cnt i=%0d act=%0d exp=24", i, shift_counter); end
    end
    do_in(6'd8, 1'b0, 32'h44, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL aps_rel_stall act=%b exp=0", stall); end
    n_checks++; if (u_if.fifo_push_en !== 1'b1) begin n_fail++; $display("FAIL aps_rel_push act=%b exp=1", u_if.fifo_push_en); end
    n_checks++; if (u_if.fifo_data !== 32'h1122_3344) begin n_fail++; $display("FAIL aps_rel_data act=%h exp=11223344", u_if.fifo_data); end
    @(negedge clk);
    idle();
    n_checks++; if (isr !== 32'd0) begin n_fail++; $display("FAIL aps_rel_isr act=%h exp=0", isr); end
    n_checks++; if (shift_counter !== 6'd0) begin n_fail++; $display("FAIL aps_rel_cnt act=%0d exp=0", shift_counter); end
  endtask

  task automatic test_push();
    do_reset(); autopush = 1'b0;
    do_in(6'd40, 1'b0, 32'hDEAD_BEEF, 1'b0); @(negedge clk);
    idle();
    n_checks++; if (shift_counter !== 6'd32) begin n_fail++; $display("FAIL push_load_cnt act=%0d exp=32", shift_counter); end
    push_req = 1'b1; push_block = 1'b1; u_if.fifo_full = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pblk_stall act=%b exp=1", stall); end
    n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL pblk_push act=%b exp=0", u_if.fifo_push_en); end
    @(negedge clk);
    n_checks++; if (isr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pblk_isr act=%h exp=deadbeef", isr); end
    push_block = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pdrop_stall act=%b exp=0", stall); end
    n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL pdrop_push act=%b exp=0", u_if.fifo_push_en); end
    @(negedge clk);
    idle();
    n_checks++; if (isr !== 32'd0) begin n_fail++; $display("FAIL pdrop_isr act=%h exp=0", isr); end
    n_checks++; if (shift_counter !== 6'd0) begin n_fail++; $display("FAIL pdrop_cnt act=%0d exp=0", shift_counter); end
    do_in(6'd16, 1'b0, 32'hFFFF_CAFE, 1'b0); @(negedge clk);
    idle(); push_req = 1'b1;
    #1;
    n_checks++; if (u_if.fifo_push_en !== 1'b1) begin n_fail++; $display("FAIL push_en act=%b exp=1", u_if.fifo_push_en); end
    n_checks++; if (u_if.fifo_data !== 32'h0000_CAFE) begin n_fail++; $display("FAIL push_data act=%h exp=0000cafe", u_if.fifo_data); end
    @(negedge clk);
    n_checks++; if (u_if.fifo_push_en !== 1'b1) begin n_fail++; $display("FAIL push_empty_en act=%b exp=1", u_if.fifo_push_en); end
    n_checks++; if (u_if.fifo_data !== 32'd0) begin n_fail++; $display("FAIL push_empty_data act=%h exp=0", u_if.fifo_data); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_shift_and_push();
    do_reset(); autopush = 1'b0;
    do_in(6'd0, 1'b1, 32'h1234_5678, 1'b0); push_req = 1'b1;
    #1;
    n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL both_push act=%b exp=0", u_if.fifo_push_en); end
    @(negedge clk);
    idle();
    n_checks++; if (isr !== 32'h1234_5678) begin n_fail++; $display("FAIL both_isr act=%h exp=12345678", isr); end
    n_checks++; if (shift_counter !== 6'd32) begin n_fail++; $display("FAIL both_cnt act=%0d exp=32", shift_counter); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset(); autopush = 1'b1; push_thresh = 5'd8;
    do_in(6'd8, 1'b0, 32'h5A, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_pre_stall act=%b exp=1", stall); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall act=%b exp=0", stall); end
    @(negedge clk);
    rst = 1'b0; idle();
    n_checks++; if (isr !== 32'd0) begin n_fail++; $display("FAIL rms_isr act=%h exp=0", isr); end
    n_checks++; if (shift_counter !== 6'd0) begin n_fail++; $display("FAIL rms_cnt act=%0d exp=0", shift_counter); end
  endtask

  task automatic test_back_to_back();
    do_reset(); autopush = 1'b1; push_thresh = 5'd4;
    for (int i = 1; i <= 3; i++) begin
      do_in(6'd8, 1'b0, 32'(i), 1'b0);
      #1;
      n_checks++; if (u_if.fifo_push_en !== 1'b1) begin n_fail++; $display("FAIL b2b_push i=%0d act=%b exp=1", i, u_if.fifo_push_en); end
      n_checks++; if (u_if.fifo_data !== 32'(i)) begin n_fail++; $display("FAIL b2b_data i=%0d act=%h exp=%h", i, u_if.fifo_data, 32'(i)); end
      @(negedge clk);
    end
    do_reset(); autopush = 1'b1; push_thresh = 5'd12;
    do_in(6'd8, 1'b0, 32'hAA, 1'b0);
    #1;
    n_checks++; if (u_if.fifo_push_en !== 1'b0) begin n_fail++; $display("FAIL thr_below act=%b exp=0", u_if.fifo_push_en); end
    @(negedge clk);
    do_in(6'd8, 1'b0, 32'hBB, 1'b0);
    #1;
    n_checks++; if (u_if.fifo_push_en !== 1'b1) begin n_fail++; $display("FAIL thr_reach act=%b exp=1", u_if.fifo_push_en); end
    n_checks++; if (u_if.fifo_data !== 32'h0000_AABB) begin n_fail++; $display("FAIL thr_data act=%h exp=0000aabb", u_if.fifo_data); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; shift_count = 6'd8; shiftdir = 1'b0; autopush = 1'b0; push_thresh = 5'd0;
    @(negedge clk);
    test_reset();
    test_shift_left();
    test_shift_right();
    test_autopush();
    test_autopush_stall();
    test_push();
    test_shift_and_push();
    test_reset_mid_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
